wb_arbiter2: RTL and testbench

//   Two-master, one-slave Wishbone classic arbiter. Shares one slave (e.g. the ram port)

---
 rtl/wb_arbiter2_pkg.sv | 25 ++
 rtl/wb_arbiter2_if.sv | 22 ++
 rtl/wb_arbiter2.sv | 131 +++++++++++++
 tb/tb_wb_arbiter2.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter2_pkg.sv
// Shared types and helpers for the two-master Wishbone classic arbiter.
// Arbiter states, master indices and the request tie-break function.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2,
        TOUT = 2'd3
    } arb_state_e;

    localparam logic M_IBUS = 1'b0;
    localparam logic M_DBUS = 1'b1;

    localparam int CNT_W = 16;

    // Index of the master to grant from IDLE; only meaningful when a request is present.
    function automatic logic pick_master(input logic req0, input logic req1,
                                         input logic fixed_prio, input logic last_gnt);
        if (req0 && req1)
            return fixed_prio ? M_DBUS : ~last_gnt;
        return req1 ? M_DBUS : M_IBUS;
    endfunction

endpackage

// File: rtl/wb_arbiter2_if.sv
// Wishbone classic bus bundle. The master modport is held by whoever initiates
// cycles (the CPU buses, and the arbiter towards the shared slave).
interface wb_arbiter2_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat_w;
    logic [DW-1:0]   dat_r;
    logic [DW/8-1:0] sel;
    logic            we;
    logic            cyc;
    logic            stb;
    logic            ack;
    logic            err;

    modport master (output adr, dat_w, sel, we, cyc, stb,
                    input  dat_r, ack, err);

    modport slave  (input  adr, dat_w, sel, we, cyc, stb,
                    output dat_r, ack, err);
endinterface

// File: rtl/wb_arbiter2.sv
// Two-master, one-slave Wishbone classic arbiter with registered, cyc-locked grants.
// Optional stalled-slave watchdog is enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter2
    import wb_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int PRIO    = 0,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    wb_arbiter2_if.slave  m0,
    wb_arbiter2_if.slave  m1,
    wb_arbiter2_if.master s
);

    arb_state_e state_q, state_d;
    logic       last_gnt_q, last_gnt_d;
    logic       pick;
    logic       timeout_hit;

    assign pick = pick_master(m0.cyc, m1.cyc, PRIO != 0, last_gnt_q);

`ifdef WB_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stall;

    assign stall = ((state_q == GNT0 && m0.stb) || (state_q == GNT1 && m1.stb)) && !s.ack;
    // Fire on the edge that would bring the count to TIMEOUT, so the slave sees exactly TIMEOUT stalled cycles.
    assign timeout_hit = stall && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        cnt_d = '0;
        if (stall)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        unique case (state_q)
            IDLE: begin
                if (m0.cyc || m1.cyc) begin
                    state_d    = pick ? GNT1 : GNT0;
                    last_gnt_d = pick;
                end
            end
            GNT0: begin
                if (!m0.cyc)
                    state_d = IDLE;
                else if (timeout_hit)
                    state_d = TOUT;
            end
            GNT1: begin
                if (!m1.cyc)
                    state_d = IDLE;
                else if (timeout_hit)
                    state_d = TOUT;
            end
            TOUT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are a pure function of state so an async reset silences the bus immediately.
    always_comb begin
        s.adr    = '0;
        s.dat_w  = '0;
        s.sel    = '0;
        s.we     = 1'b0;
        s.cyc    = 1'b0;
        s.stb    = 1'b0;
        m0.dat_r = '0;
        m0.ack   = 1'b0;
        m0.err   = 1'b0;
        m1.dat_r = '0;
        m1.ack   = 1'b0;
        m1.err   = 1'b0;
        unique case (state_q)
            GNT0: begin
                s.adr    = m0.adr;
                s.dat_w  = m0.dat_w;
                s.sel    = m0.sel;
                s.we     = m0.we;
                s.cyc    = m0.cyc;
                s.stb    = m0.stb;
                m0.dat_r = s.dat_r;
                m0.ack   = s.ack;
            end
            GNT1: begin
                s.adr    = m1.adr;
                s.dat_w  = m1.dat_w;
                s.sel    = m1.sel;
                s.we     = m1.we;
                s.cyc    = m1.cyc;
                s.stb    = m1.stb;
                m1.dat_r = s.dat_r;
                m1.ack   = s.ack;
            end
`ifdef WB_ARB_TIMEOUT_EN
            TOUT: begin
                m0.err = (last_gnt_q == M_IBUS);
                m1.err = (last_gnt_q == M_DBUS);
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2: one round-robin and one fixed-priority instance.
// Timeout scenario follows WB_ARB_TIMEOUT_EN as defined for the build.
module tb_wb_arbiter2;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    wb_arbiter2_if #(.AW(32), .DW(32)) rm0 ();
    wb_arbiter2_if #(.AW(32), .DW(32)) rm1 ();
    wb_arbiter2_if #(.AW(32), .DW(32)) rs ();
    wb_arbiter2_if #(.AW(32), .DW(32)) fm0 ();
    wb_arbiter2_if #(.AW(32), .DW(32)) fm1 ();
    wb_arbiter2_if #(.AW(32), .DW(32)) fs ();

    wb_arbiter2 #(.AW(32), .DW(32), .PRIO(0), .TIMEOUT(4)) dut_rr (
        .clk(clk), .reset(rst), .m0(rm0), .m1(rm1), .s(rs));

    wb_arbiter2 #(.AW(32), .DW(32), .PRIO(1), .TIMEOUT(4)) dut_fp (
        .clk(clk), .reset(rst), .m0(fm0), .m1(fm1), .s(fs));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rr(input logic idx, input logic c);
        if (idx) begin rm1.cyc = c; rm1.stb = c; end
        else     begin rm0.cyc = c; rm0.stb = c; end
    endtask

    task automatic set_fp(input logic idx, input logic c);
        if (idx) begin fm1.cyc = c; fm1.stb = c; end
        else     begin fm0.cyc = c; fm0.stb = c; end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rm0.cyc = 1'b1; rm0.stb = 1'b1; rm0.adr = 32'h1234_5678;
        rs.ack = 1'b1; rs.dat_r = 32'hDEAD_BEEF;
        tick();
        checks++; if (rs.cyc !== 1'b0 || rs.stb !== 1'b0) begin errors++; $display("FAIL reset_cyc_stb: got %b%b exp 00", rs.cyc, rs.stb); end
        checks++; if (rs.adr !== 32'h0 || rs.dat_w !== 32'h0 || rs.sel !== 4'h0 || rs.we !== 1'b0) begin errors++; $display("FAIL reset_fields: adr %h dat %h sel %h we %b exp all 0", rs.adr, rs.dat_w, rs.sel, rs.we); end
        checks++; if (rm0.ack !== 1'b0 || rm0.dat_r !== 32'h0 || rm0.err !== 1'b0) begin errors++; $display("FAIL reset_m0: ack %b dat %h err %b exp 0", rm0.ack, rm0.dat_r, rm0.err); end
        checks++; if (rm1.ack !== 1'b0 || rm1.dat_r !== 32'h0 || fs.cyc !== 1'b0) begin errors++; $display("FAIL reset_m1_fp: m1ack %b m1dat %h fscyc %b exp 0", rm1.ack, rm1.dat_r, fs.cyc); end
        set_rr(1'b0, 1'b0);
        rm0.adr = 32'h0; rs.ack = 1'b0; rs.dat_r = 32'h0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        rm0.adr = 32'h8000_0010; rm0.we = 1'b0; rm0.sel = 4'hF;
        set_rr(1'b0, 1'b1);
        #1;
        checks++; if (rs.cyc !== 1'b0) begin errors++; $display("FAIL t1_latency: s_cyc %b exp 0", rs.cyc); end
        tick();
        checks++; if (rs.cyc !== 1'b1 || rs.stb !== 1'b1) begin errors++; $display("FAIL t1_grant: cyc/stb %b%b exp 11", rs.cyc, rs.stb); end
        checks++; if (rs.adr !== 32'h8000_0010 || rs.sel !== 4'hF) begin errors++; $display("FAIL t1_adr: adr %h sel %h exp 80000010 f", rs.adr, rs.sel); end
        tick();
        rs.ack = 1'b1; rs.dat_r = 32'hDEAD_BEEF;
        #1;
        checks++; if (rm0.ack !== 1'b1 || rm0.dat_r !== 32'hDEAD_BEEF) begin errors++; $display("FAIL t1_ack: ack %b dat %h exp 1 deadbeef", rm0.ack, rm0.dat_r); end
        checks++; if (rm1.ack !== 1'b0 || rm1.dat_r !== 32'h0) begin errors++; $display("FAIL t1_m1_quiet: ack %b dat %h exp 0 0", rm1.ack, rm1.dat_r); end
        tick();
        rs.ack = 1'b0; rs.dat_r = 32'h0;
        set_rr(1'b0, 1'b0);
        #1;
        checks++; if (rs.cyc !== 1'b0) begin errors++; $display("FAIL t1_release: s_cyc %b exp 0", rs.cyc); end
        tick();
    endtask

    task automatic test_round_robin();
        logic exp;
        pulse_reset();
        rm0.adr = 32'h0000_0100; rm1.adr = 32'h0000_0200;
        set_rr(1'b0, 1'b1); set_rr(1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            exp = (k % 2 == 1);
            set_rr(exp, 1'b1);
            #1;
            checks++; if (rs.cyc !== 1'b0) begin errors++; $display("FAIL rr_dead_%0d: s_cyc %b exp 0", k, rs.cyc); end
            tick();
            checks++; if (rs.adr !== (exp ? 32'h0000_0200 : 32'h0000_0100) || rs.cyc !== 1'b1) begin errors++; $display("FAIL rr_grant_%0d: adr %h cyc %b exp m%0d", k, rs.adr, rs.cyc, exp); end
            rs.ack = 1'b1; rs.dat_r = 32'h1000 + k;
            #1;
            checks++; if ((exp ? rm1.ack : rm0.ack) !== 1'b1 || (exp ? rm0.ack : rm1.ack) !== 1'b0) begin errors++; $display("FAIL rr_ack_%0d: m0 %b m1 %b exp m%0d only", k, rm0.ack, rm1.ack, exp); end
            tick();
            rs.ack = 1'b0;
            set_rr(exp, 1'b0);
            tick();
        end
        set_rr(1'b0, 1'b0); set_rr(1'b1, 1'b0);
        tick();
    endtask

    task automatic test_fixed_prio();
        fm0.adr = 32'h0000_0100; fm1.adr = 32'h0000_0200;
        set_fp(1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            set_fp(1'b1, 1'b1);
            tick();
            checks++; if (fs.adr !== 32'h0000_0200 || fs.cyc !== 1'b1) begin errors++; $display("FAIL fp_grant_%0d: adr %h cyc %b exp 00000200 1", k, fs.adr, fs.cyc); end
            tick();
            set_fp(1'b1, 1'b0);
            tick();
        end
        #1;
        checks++; if (fs.cyc !== 1'b0) begin errors++; $display("FAIL fp_dead: s_cyc %b exp 0", fs.cyc); end
        tick();
        checks++; if (fs.adr !== 32'h0000_0100 || fs.cyc !== 1'b1) begin errors++; $display("FAIL fp_m0_alone: adr %h cyc %b exp 00000100 1", fs.adr, fs.cyc); end
        set_fp(1'b0, 1'b0);
        tick();
    endtask

    task automatic test_write_while_waiting();
        rm1.adr = 32'h1000_0000; rm1.dat_w = 32'h0000_00A5; rm1.sel = 4'h1; rm1.we = 1'b1;
        set_rr(1'b1, 1'b1);
        tick();
        rm0.adr = 32'h0000_0100; rm0.dat_w = 32'hFFFF_FFFF; rm0.sel = 4'hF; rm0.we = 1'b0;
        set_rr(1'b0, 1'b1);
        #1;
        checks++; if (rs.adr !== 32'h1000_0000 || rs.dat_w !== 32'h0000_00A5 || rs.sel !== 4'h1 || rs.we !== 1'b1) begin errors++; $display("FAIL t4_fields: adr %h dat %h sel %h we %b exp 10000000 a5 1 1", rs.adr, rs.dat_w, rs.sel, rs.we); end
        rs.ack = 1'b1;
        #1;
        checks++; if (rm1.ack !== 1'b1 || rm0.ack !== 1'b0) begin errors++; $display("FAIL t4_ack: m1 %b m0 %b exp 1 0", rm1.ack, rm0.ack); end
        tick();
        rs.ack = 1'b0;
        set_rr(1'b1, 1'b0);
        #1;
        checks++; if (rs.cyc !== 1'b0) begin errors++; $display("FAIL t4_release: s_cyc %b exp 0", rs.cyc); end
        tick();
        checks++; if (rs.cyc !== 1'b0) begin errors++; $display("FAIL t4_dead: s_cyc %b exp 0", rs.cyc); end
        tick();
        checks++; if (rs.adr !== 32'h0000_0100 || rs.we !== 1'b0 || rs.cyc !== 1'b1) begin errors++; $display("FAIL t4_m0_grant: adr %h we %b cyc %b exp 00000100 0 1", rs.adr, rs.we, rs.cyc); end
        set_rr(1'b0, 1'b0);
        rm1.we = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_cycle();
        set_rr(1'b0, 1'b1);
        tick();
        checks++; if (rs.stb !== 1'b1) begin errors++; $display("FAIL t5_pre: s_stb %b exp 1", rs.stb); end
        rs.ack = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (rs.cyc !== 1'b0 || rs.stb !== 1'b0 || rm0.ack !== 1'b0) begin errors++; $display("FAIL t5_drop: cyc %b stb %b ack %b exp 000", rs.cyc, rs.stb, rm0.ack); end
        set_rr(1'b0, 1'b0);
        rs.ack = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        checks++; if (rs.cyc !== 1'b0) begin errors++; $display("FAIL t5_idle: s_cyc %b exp 0", rs.cyc); end
    endtask

    task automatic test_timeout();
        rm0.adr = 32'h0000_0300;
        set_rr(1'b0, 1'b1);
        tick();
`ifdef WB_ARB_TIMEOUT_EN
        for (int k = 0; k < 4; k++) begin
            checks++; if (rs.cyc !== 1'b1 || rm0.err !== 1'b0) begin errors++; $display("FAIL t6_stall_%0d: cyc %b err %b exp 1 0", k, rs.cyc, rm0.err); end
            if (k < 3) tick();
            else @(posedge clk);
        end
        #1;
        checks++; if (rm0.err !== 1'b1 || rs.cyc !== 1'b0 || rs.stb !== 1'b0) begin errors++; $display("FAIL t6_err: err %b cyc %b stb %b exp 1 0 0", rm0.err, rs.cyc, rs.stb); end
        checks++; if (rm1.err !== 1'b0) begin errors++; $display("FAIL t6_m1_err: err %b exp 0", rm1.err); end
        set_rr(1'b0, 1'b0);
        tick();
        checks++; if (rm0.err !== 1'b0 || rs.cyc !== 1'b0) begin errors++; $display("FAIL t6_after: err %b cyc %b exp 0 0", rm0.err, rs.cyc); end
`else
        for (int k = 0; k < 8; k++) begin
            checks++; if (rm0.err !== 1'b0 || rs.cyc !== 1'b1) begin errors++; $display("FAIL t6_hang_%0d: err %b cyc %b exp 0 1", k, rm0.err, rs.cyc); end
            tick();
        end
        set_rr(1'b0, 1'b0);
        tick();
`endif
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        rm0.adr = '0; rm0.dat_w = '0; rm0.sel = '0; rm0.we = 1'b0; rm0.cyc = 1'b0; rm0.stb = 1'b0;
        rm1.adr = '0; rm1.dat_w = '0; rm1.sel = '0; rm1.we = 1'b0; rm1.cyc = 1'b0; rm1.stb = 1'b0;
        fm0.adr = '0; fm0.dat_w = '0; fm0.sel = '0; fm0.we = 1'b0; fm0.cyc = 1'b0; fm0.stb = 1'b0;
        fm1.adr = '0; fm1.dat_w = '0; fm1.sel = '0; fm1.we = 1'b0; fm1.cyc = 1'b0; fm1.stb = 1'b0;
        rs.dat_r = '0; rs.ack = 1'b0; rs.err = 1'b0;
        fs.dat_r = '0; fs.ack = 1'b0; fs.err = 1'b0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_fixed_prio();
        test_write_while_waiting();
        test_reset_mid_cycle();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
